// File: rtl/lfsr_stim_seq_if.sv
// ---------------------------------------------------------------------------
// lfsr_stim_seq_if
// Vector stream between the stimulus sequencer and the LFSR core.
//   out_vld  source -> sink  vector valid
//   out_rdy  sink -> source  consumer ready
//   seq_num  source -> sink  seed value (WIDTH bits)
//   sw_in    source -> sink  switch value (WIDTH bits)
//   vec_idx  source -> sink  table index of the presented vector (AW bits)
// master = sequencer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface lfsr_stim_seq_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] seq_num;
  logic [WIDTH-1:0] sw_in;
  logic [AW-1:0]    vec_idx;

  modport master (
    output out_vld,
    output seq_num,
    output sw_in,
    output vec_idx,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  seq_num,
    input  sw_in,
    input  vec_idx,
    output out_rdy
  );
endinterface

// File: rtl/lfsr_stim_seq.sv
// ---------------------------------------------------------------------------
// lfsr_stim_seq
// Plays back a run-time-loadable table of (seq_num, sw_in) pairs to the LFSR
// core over a valid/ready handshake, with an optional idle gap between
// vectors, loop mode and chained-seed mode.
//
// Parameters: WIDTH (vector width), DEPTH (table entries, >= 2),
//             GAP (idle cycles between an accepted vector and the next).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle run start (ignored while busy)
//   abort                stop the current run, no done pulse
//   num_vec              vectors per pass (0 = empty run, clamped to DEPTH)
//   loop_en, chain_en    wrap to entry 0 / seed from previous sw_in
//   wr_en, wr_addr,
//   wr_seq, wr_sw        table write port (out-of-range addresses dropped)
//   vec                  vector stream (master side)
//   busy                 run in progress
//   done                 one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module lfsr_stim_seq #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  parameter  int GAP   = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AW:0]          num_vec,
  input  logic                 loop_en,
  input  logic                 chain_en,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_seq,
  input  logic [WIDTH-1:0]     wr_sw,
  lfsr_stim_seq_if.master      vec,
  output logic                 busy,
  output logic                 done
);

  // Gap counter holds GAP-1 at most; keep at least one bit when GAP <= 1.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAPW,
    DONE
  } state_t;

  state_t           state;
  logic [AW:0]      num_r;
  logic             loop_r;
  logic             chain_r;
  logic [GW-1:0]    gap_cnt;

  logic [WIDTH-1:0] tab_seq [DEPTH];
  logic [WIDTH-1:0] tab_sw  [DEPTH];

  logic             last;
  logic [AW-1:0]    nxt_idx;
  logic [WIDTH-1:0] ld_seq;
  logic [WIDTH-1:0] ld_sw;
  logic [AW:0]      num_c;

  // -------------------------------------------------------------------------
  // Vector table. Matching each entry against wr_addr drops out-of-range
  // writes naturally when DEPTH is not a power of two.
  // -------------------------------------------------------------------------
  // NOTE: the table is plain flops with an async reset so a run after reset
  // always plays back zeros; a RAM macro could not offer that guarantee.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_seq[i] <= '0;
        tab_sw[i]  <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == AW'(i)) begin
          tab_seq[i] <= wr_seq;
          tab_sw[i]  <= wr_sw;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-vector selection. vec_idx stays on the last presented vector during
  // a gap, so the same decode serves both the back-to-back and gap paths.
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a value on every path, otherwise
  // synthesis would infer latches.
  always_comb begin
    num_c   = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    last    = ({1'b0, vec.vec_idx} == (num_r - 1'b1));
    nxt_idx = last ? '0 : vec.vec_idx + 1'b1;
    ld_sw   = tab_sw[nxt_idx];
    // Chained seed: the previous switch value seeds the next vector, except
    // at entry 0 (including a loop wrap) which always restarts from the table.
    ld_seq  = (chain_r && (nxt_idx != '0)) ? vec.sw_in : tab_seq[nxt_idx];
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // -------------------------------------------------------------------------
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      num_r       <= '0;
      loop_r      <= 1'b0;
      chain_r     <= 1'b0;
      gap_cnt     <= '0;
      vec.out_vld <= 1'b0;
      vec.seq_num <= '0;
      vec.sw_in   <= '0;
      vec.vec_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Vector fields hold their last values for post-mortem inspection.
        state       <= IDLE;
        vec.out_vld <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              busy <= 1'b1;
              if (num_vec == '0) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                num_r       <= num_c;
                loop_r      <= loop_en;
                chain_r     <= chain_en;
                vec.seq_num <= tab_seq[0];
                vec.sw_in   <= tab_sw[0];
                vec.vec_idx <= '0;
                vec.out_vld <= 1'b1;
                state       <= PRESENT;
              end
            end
          end

          PRESENT: begin
            if (vec.out_rdy) begin
              if (last && !loop_r) begin
                vec.out_vld <= 1'b0;
                done        <= 1'b1;
                state       <= DONE;
              end else if (GAP == 0) begin
                vec.seq_num <= ld_seq;
                vec.sw_in   <= ld_sw;
                vec.vec_idx <= nxt_idx;
              end else begin
                vec.out_vld <= 1'b0;
                gap_cnt     <= GW'(GAP - 1);
                state       <= GAPW;
              end
            end
          end

          GAPW: begin
            if (gap_cnt == '0) begin
              vec.seq_num <= ld_seq;
              vec.sw_in   <= ld_sw;
              vec.vec_idx <= nxt_idx;
              vec.out_vld <= 1'b1;
              state       <= PRESENT;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end

          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stim_seq.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stim_seq
// Two sequencers share the control and table inputs: dut_a with GAP = 2 and
// dut_b with GAP = 0, each with its own out_rdy. Expected vectors come from a
// model of the table: vector k of a pass is (seq[k], sw[k]), or
// (sw[k-1], sw[k]) in chain mode for k > 0, repeated modulo the pass length.
// ---------------------------------------------------------------------------
module tb_lfsr_stim_seq;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [AW:0]      num_vec = '0;
  logic             loop_en = 1'b0;
  logic             chain_en = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_seq = '0;
  logic [WIDTH-1:0] wr_sw = '0;
  logic             busy_a, done_a, busy_b, done_b;

  always #5 clk = ~clk;

  lfsr_stim_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_a ();
  lfsr_stim_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_b ();

  lfsr_stim_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vec(num_vec), .loop_en(loop_en), .chain_en(chain_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_seq(wr_seq), .wr_sw(wr_sw),
    .vec(if_a), .busy(busy_a), .done(done_a)
  );

  lfsr_stim_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vec(num_vec), .loop_en(loop_en), .chain_en(chain_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_seq(wr_seq), .wr_sw(wr_sw),
    .vec(if_b), .busy(busy_b), .done(done_b)
  );

  // Per-DUT views, index 0 = dut_a, 1 = dut_b.
  logic             vld [2];
  logic             bsy [2];
  logic             dn  [2];
  logic [WIDTH-1:0] sq  [2];
  logic [WIDTH-1:0] sw  [2];
  logic [AW-1:0]    ix  [2];
  logic             rdy [2];

  assign vld[0] = if_a.out_vld;  assign vld[1] = if_b.out_vld;
  assign bsy[0] = busy_a;        assign bsy[1] = busy_b;
  assign dn[0]  = done_a;        assign dn[1]  = done_b;
  assign sq[0]  = if_a.seq_num;  assign sq[1]  = if_b.seq_num;
  assign sw[0]  = if_a.sw_in;    assign sw[1]  = if_b.sw_in;
  assign ix[0]  = if_a.vec_idx;  assign ix[1]  = if_b.vec_idx;
  assign if_a.out_rdy = rdy[0];
  assign if_b.out_rdy = rdy[1];

  // Table model.
  logic [WIDTH-1:0] m_seq [DEPTH];
  logic [WIDTH-1:0] m_sw  [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // One clock: inputs set before the call are sampled at this edge, outputs
  // are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_vld"},  32'(vld[d]), 0);
      check({tag, "_busy"}, 32'(bsy[d]), 0);
      check({tag, "_done"}, 32'(dn[d]),  0);
      check({tag, "_seq"},  32'(sq[d]),  0);
      check({tag, "_sw"},   32'(sw[d]),  0);
      check({tag, "_idx"},  32'(ix[d]),  0);
    end
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] w);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_seq  = s;
    wr_sw   = w;
    step();
    wr_en = 1'b0;
    m_seq[a] = s;
    m_sw[a]  = w;
  endtask

  // ready modes: 0 = always ready, 1 = random, 2 = three stalls on vector 1
  // Runs one pass (or a looped run cut by abort once dut_a has accepted
  // abort_k vectors and sits in its gap). restart_at pulses start mid-run.
  task automatic run_check(input int num, input bit lp, input bit ch,
                           input int mode0, input int mode1,
                           input int abort_k, input int restart_at);
    int               n;
    int               cyc;
    int               k     [2];
    int               stage [2];
    int               gapc  [2];
    int               stall [2];
    int               mode  [2];
    int               ei;
    bit               do_abort;
    logic             pv    [2];
    logic             pr    [2];
    logic [WIDTH-1:0] ps    [2];
    logic [WIDTH-1:0] pw    [2];
    logic [AW-1:0]    pi    [2];
    logic [WIDTH-1:0] es    [DEPTH];
    logic [WIDTH-1:0] ew    [DEPTH];

    n = (num > DEPTH) ? DEPTH : num;
    for (int j = 0; j < DEPTH; j++) begin
      ew[j] = m_sw[j];
      es[j] = (ch && j > 0) ? m_sw[j-1] : m_seq[j];
    end
    mode[0] = mode0;
    mode[1] = mode1;

    num_vec  = (AW+1)'(num);
    loop_en  = lp;
    chain_en = ch;
    start    = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;

    if (n == 0) begin
      for (int d = 0; d < 2; d++) begin
        check("empty_vld",  32'(vld[d]), 0);
        check("empty_done", 32'(dn[d]),  1);
        check("empty_busy", 32'(bsy[d]), 1);
      end
      step();
      for (int d = 0; d < 2; d++) begin
        check("empty_vld2",  32'(vld[d]), 0);
        check("empty_done2", 32'(dn[d]),  0);
        check("empty_busy2", 32'(bsy[d]), 0);
      end
      return;
    end

    for (int d = 0; d < 2; d++) begin
      check("start_vld",  32'(vld[d]), 1);
      check("start_busy", 32'(bsy[d]), 1);
      k[d] = 0; stage[d] = 0; gapc[d] = 0; stall[d] = 0;
    end
    do_abort = 1'b0;

    while (!(stage[0] == 2 && stage[1] == 2) && cyc < 300) begin
      for (int d = 0; d < 2; d++) begin
        case (mode[d])
          0: rdy[d] = 1'b1;
          1: rdy[d] = ($urandom_range(0, 3) != 0);
          default: begin
            if (vld[d] && ix[d] == 1 && stall[d] < 3) begin
              rdy[d] = 1'b0;
              stall[d]++;
            end else begin
              rdy[d] = 1'b1;
            end
          end
        endcase
        pv[d] = vld[d]; pr[d] = rdy[d];
        ps[d] = sq[d];  pw[d] = sw[d]; pi[d] = ix[d];
      end
      start = (cyc == restart_at);
      if (start) num_vec = 3'd1;
      abort = do_abort;
      step();
      start = 1'b0;
      abort = 1'b0;
      cyc++;

      if (do_abort) begin
        for (int d = 0; d < 2; d++) begin
          check("abort_vld",  32'(vld[d]), 0);
          check("abort_busy", 32'(bsy[d]), 0);
          check("abort_done", 32'(dn[d]),  0);
          check("abort_idx",  32'(ix[d]),  32'(pi[d]));
        end
        step();
        for (int d = 0; d < 2; d++) begin
          check("abort_done2", 32'(dn[d]),  0);
          check("abort_busy2", 32'(bsy[d]), 0);
        end
        return;
      end

      for (int d = 0; d < 2; d++) begin
        if (stage[d] == 1) begin
          check("post_done", 32'(dn[d]),  0);
          check("post_busy", 32'(bsy[d]), 0);
          check("post_vld",  32'(vld[d]), 0);
          stage[d] = 2;
        end else if (stage[d] == 0) begin
          if (pv[d] && pr[d]) begin
            ei = k[d] % n;
            check("hs_seq", 32'(ps[d]), 32'(es[ei]));
            check("hs_sw",  32'(pw[d]), 32'(ew[ei]));
            check("hs_idx", 32'(pi[d]), 32'(ei));
            k[d]++;
            if (!lp && k[d] == n) begin
              check("last_vld",  32'(vld[d]), 0);
              check("done_pulse", 32'(dn[d]), 1);
              if (mode[d] == 0)
                check("run_len", 32'(cyc), 32'(n + (n - 1) * gap_of(d) + 1));
              stage[d] = 1;
            end else begin
              check("mid_done", 32'(dn[d]), 0);
              gapc[d] = vld[d] ? 0 : 1;
              if (gap_of(d) == 0) check("b2b_vld", 32'(vld[d]), 1);
            end
          end else if (pv[d]) begin
            check("hold_vld", 32'(vld[d]), 1);
            check("hold_seq", 32'(sq[d]),  32'(ps[d]));
            check("hold_sw",  32'(sw[d]),  32'(pw[d]));
            check("hold_idx", 32'(ix[d]),  32'(pi[d]));
          end else begin
            check("gap_busy", 32'(bsy[d]), 1);
            check("gap_done", 32'(dn[d]),  0);
            if (!vld[d]) gapc[d]++;
            else check("gap_len", 32'(gapc[d]), 32'(gap_of(d)));
          end
        end
      end

      if (abort_k > 0 && stage[0] == 0 && k[0] >= abort_k && !vld[0] && bsy[0])
        do_abort = 1'b1;
    end

    if (!(stage[0] == 2 && stage[1] == 2)) check("timeout", 0, 1);
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) begin
      m_seq[j] = '0;
      m_sw[j]  = '0;
    end
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;

    // Reset defaults.
    #2;
    chk_zero("rst_hold");
    #20;
    rst_n = 1'b1;
    repeat (5) step();
    chk_zero("rst_idle");

    // Playback with exact timing on dut_a.
    wr(0, 8'h01, 8'h03);
    wr(1, 8'h03, 8'h11);
    wr(2, 8'h11, 8'h30);
    wr(3, 8'h30, 8'h21);
    run_check(4, 1'b0, 1'b0, 0, 0, 0, 0);

    // Chained seeds.
    wr(1, 8'hFF, 8'h11);
    wr(2, 8'hFF, 8'h30);
    wr(3, 8'hFF, 8'h21);
    run_check(4, 1'b0, 1'b1, 0, 0, 0, 0);

    // Backpressure on vector 1 plus a start while busy.
    wr(1, 8'h03, 8'h11);
    wr(2, 8'h11, 8'h30);
    wr(3, 8'h30, 8'h21);
    run_check(4, 1'b0, 1'b0, 0, 2, 0, 3);

    // Loop with abort in the gap.
    run_check(2, 1'b1, 1'b0, 0, 1, 5, 0);

    // Empty run and oversize num_vec.
    run_check(0, 1'b0, 1'b0, 0, 0, 0, 0);
    run_check(7, 1'b0, 1'b0, 0, 0, 0, 0);

    // Randomized tables and run settings.
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < DEPTH; j++)
        wr(j, WIDTH'($urandom), WIDTH'($urandom));
      run_check(int'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, 0);
    end
    run_check(3, 1'b1, 1'b1, 1, 1, 4, 0);

    // Reset in the middle of a presented vector.
    wr(0, 8'hA5, 8'h5A);
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    num_vec = 3'd4;
    loop_en = 1'b0;
    chain_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      m_seq[j] = '0;
      m_sw[j]  = '0;
    end
    step();
    run_check(4, 1'b0, 1'b0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
